byte_serializer8: RTL
=====================

Name: byte_serializer8

Overview:
- Parallel-in, serial-out transmitter for the team's 8-bit register datapath.
- Accepts a byte over a valid/ready load handshake and shifts it out on a single data line, with a frame-enable qualifier.
- Each bit is held for a programmable number of clock cycles.
- Sits between an 8-bit holding register and a serial link; the matching deserializer is the receive end.

Parameters:
- WIDTH, 8, bits per frame; legal range ≥2.
- DIV, 4, clock cycles each bit is held on sdata; legal range ≥1.
- MSB_FIRST, 1, 1 = shift MSB first, 0 = shift LSB first.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel byte; sampled only on an accept edge.
- load_valid  input  1  source has a byte on din.
- load_ready  output  1  serializer can accept; equals (state==IDLE).
- sdata  output  1  serial data bit.
- sframe  output  1  high while a frame is being shifted.
- busy  output  1  equals sframe.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (reset, asynchronous, active-high; clock clock): outputs take these values immediately:
  - state = IDLE, sdata = 0, sframe = 0, busy = 0, done = 0, load_ready = 1.
  - Shift register, bit counter and divider counter all = 0.
- States: IDLE and SHIFT only.
- IDLE:
  - load_ready = 1, sdata = 0, sframe = 0.
  - Accept = load_valid && load_ready at a rising edge.
  - On accept: capture din into the shift register, clear bit counter and divider counter, go to SHIFT.
- SHIFT:
  - load_ready = 0, sframe = busy = 1.
  - sdata = shreg[WIDTH-1] when MSB_FIRST=1, otherwise shreg[0].
  - Divider counter counts 0..DIV-1; on DIV-1 it wraps to 0 (the bit tick).
  - On each bit tick: shift the register by one toward the output end, zero-filling, and increment the bit counter.
  - On the bit tick where bit counter == WIDTH-1: go to IDLE and assert done for exactly one cycle.
- Timing, with the accept at edge E:
  - Bit k is driven during cycles E+k·DIV … E+(k+1)·DIV−1.
  - sframe is high for exactly WIDTH·DIV cycles.
  - done and load_ready both rise at edge E+WIDTH·DIV.
  - Earliest next accept is edge E+WIDTH·DIV+1, so the minimum frame period is WIDTH·DIV+1 cycles.
- All outputs are decoded from flops only: no combinational path from any input to any output.
- load_valid while in SHIFT: ignored. The source holds din and load_valid until accepted; a din change mid-frame has no effect.
- load_valid high at reset release: accepted at the first rising edge after reset deasserts.
- DIV=1: one bit per cycle, no idle cycles inside the frame.
- Reset mid-frame: the frame is aborted, the in-flight byte is dropped, no done pulse; after release the block is in IDLE with load_ready=1.
- Counters: bit counter width is clog2(WIDTH); divider counter width is clog2(DIV) with a minimum of 1. Neither counter exceeds its terminal value.

Decomposition:
- Shared package/header holds:
  - state encoding constants ST_IDLE=0, ST_SHIFT=1;
  - default WIDTH and DIV;
  - a clog2 helper.
- One natural sub-module: bit_tick_gen.
  - Parameter DIV; inputs clock, reset, clear, enable; output tick.
  - Asserts tick every DIV enabled cycles; restarts on clear, which is driven by the accept.
- The FSM, shift register and bit counter stay in byte_serializer8.

Test Plan:
- Reset then idle → sdata=0, sframe=0, done=0, load_ready=1 held for 10 cycles with load_valid=0.
- WIDTH=8, DIV=4, MSB_FIRST=1, din=8'hA5 accepted at edge E:
  - sdata sequence 1,0,1,0,0,1,0,1, each held 4 cycles;
  - sframe high 32 cycles;
  - done a single pulse at E+32.
- MSB_FIRST=0, DIV=1, din=8'b11110100 → sdata 0,0,1,0,1,1,1,1 on consecutive cycles; done at E+8.
- Back-to-back with load_valid held high, din=8'h01 then 8'h80 (DIV=4):
  - second accept at E+33;
  - exactly one low sframe cycle between frames;
  - din changed mid-frame does not corrupt frame 1.
- Assert reset at the 3rd bit of din=8'hFF (DIV=4):
  - sdata and sframe drop to 0 asynchronously, no done pulse;
  - after release, a new byte 8'h54 serializes correctly.
- load_valid pulses during SHIFT → not accepted; frame and done timing unchanged; load_ready stays 0 until frame end.

Source files
------------

// File: rtl/byte_serializer8_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | byte_serializer8_pkg : shared state encoding, defaults, clog2       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package byte_serializer8_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int c_DEF_WIDTH = 8;
  localparam int c_DEF_DIV   = 4;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bit_tick_gen : one tick every DIV enabled cycles, restart on clear  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module bit_tick_gen
  import byte_serializer8_pkg::*;
#(
  parameter int DIV = c_DEF_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int              c_CW   = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  logic [c_CW-1:0] r_cnt;
  logic            w_last;

  assign w_last = (r_cnt == c_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_last ? '0 : r_cnt + c_ONE;
    end
  end

  assign tick = enable && w_last;

endmodule
`default_nettype wire

// File: rtl/byte_serializer8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | byte_serializer8 : valid/ready loaded parallel-in serial-out shifter|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module byte_serializer8
  import byte_serializer8_pkg::*;
#(
  parameter int WIDTH     = c_DEF_WIDTH,
  parameter int DIV       = c_DEF_DIV,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdata,
  output logic             sframe,
  output logic             busy,
  output logic             done
);

  localparam int              c_BW       = clog2(WIDTH);
  localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(WIDTH - 1);
  localparam logic [c_BW-1:0] c_BIT_ONE  = c_BW'(1);

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_shreg, w_shreg_next;
  logic [c_BW-1:0]  r_bitcnt, w_bitcnt_next;
  logic             r_done, w_done_next;
  logic             w_accept;
  logic             w_tick;
  logic             w_shifting;
  logic             w_out_bit;

  assign w_shifting = (r_state == ST_SHIFT);
  assign w_accept   = load_valid && (r_state == ST_IDLE);

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_accept),
    .enable (w_shifting),
    .tick   (w_tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_shreg  <= w_shreg_next;
      r_bitcnt <= w_bitcnt_next;
      r_done   <= w_done_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_shreg_next  = r_shreg;
    w_bitcnt_next = r_bitcnt;
    w_done_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_shreg_next  = din;
          w_bitcnt_next = '0;
          w_state_next  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_tick) begin
          // zero-fill so the register is empty once the frame ends
          w_shreg_next = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                   : {1'b0, r_shreg[WIDTH-1:1]};
          if (r_bitcnt == c_BIT_LAST) begin
            w_bitcnt_next = '0;
            w_state_next  = ST_IDLE;
            w_done_next   = 1'b1;
          end else begin
            w_bitcnt_next = r_bitcnt + c_BIT_ONE;
          end
        end
      end
    endcase
  end

  if (MSB_FIRST) begin : g_msb_first
    assign w_out_bit = r_shreg[WIDTH-1];
  end else begin : g_lsb_first
    assign w_out_bit = r_shreg[0];
  end

  assign load_ready = (r_state == ST_IDLE);
  assign sframe     = w_shifting;
  assign busy       = w_shifting;
  assign sdata      = w_shifting & w_out_bit;
  assign done       = r_done;

endmodule
`default_nettype wire
